lut_sweep_engine: RTL and testbench
===================================

Name: lut_sweep_engine

Overview:
- Sequential, parametrised truth-table generator. Holds a programmable N_IN-input single-output Boolean function as a 2^N_IN-entry lookup table.
- On `start`, walks every input combination from 0 to 2^N_IN-1 and presents each row through a valid/ready stream. A one-count summary is reported at the end of the sweep.
- Sits between a configuration source and a display/checker consumer, replacing fixed-function combinational evaluators with hand-written sweep loops.

Parameters:
- N_IN, 4, number of function inputs. Table depth is 2^N_IN; legal range 1..8.
- GAP, 0, idle cycles inserted after each accepted row before the next row is presented; legal range 0..15.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  N_IN  table entry (minterm index) to write.
- cfg_bit  in  1  function value for that minterm.
- start  in  1  single-cycle sweep request.
- busy  out  1  high from the cycle after an accepted start until done.
- row_valid  out  1  row_index/row_out hold a valid row.
- row_ready  in  1  consumer accepts the row when high together with row_valid.
- row_index  out  N_IN  input combination of the current row; MSB is the highest-weight input.
- row_out  out  1  table value at row_index.
- done  out  1  one-cycle pulse after the last row is accepted.
- ones_count  out  N_IN+1  number of accepted rows with row_out=1 in the last sweep.

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0:
  - every table entry;
  - busy, row_valid, row_index, row_out, done, ones_count;
  - the GAP counter.
  - State returns to IDLE.
- States are IDLE, SHOW, GAP, DONE.
- IDLE:
  - cfg_we=1 writes cfg_bit into entry cfg_addr at the clock edge.
  - start=1 moves to SHOW next cycle: row_index=0, ones_count=0, busy=1, row_valid=1.
  - cfg_we and start in the same cycle: the write is performed and the sweep starts; row 0 reflects the write if cfg_addr=0.
- SHOW:
  - row_valid=1; row_out = table[row_index], registered, available in the same cycle row_index is presented.
  - row_index and row_out are held stable until row_valid & row_ready.
  - On accept: ones_count += row_out.
  - On accept with row_index = 2^N_IN-1: go to DONE.
  - On accept otherwise with GAP=0: row_index+1, stay in SHOW. Back-to-back rows allow one row per cycle under continuous ready.
  - On accept otherwise with GAP>0: row_valid=0, go to GAP.
- GAP: hold row_valid=0 for GAP cycles, then SHOW with row_index+1.
- DONE:
  - Single cycle with done=1, busy=0, row_valid=0; then IDLE.
  - ones_count holds its final value until the next accepted start.
- Termination is by comparing row_index against all-ones, never by counter overflow. The internal row counter and ones_count are N_IN+1 bits so a full table (2^N_IN ones) is representable.
- While busy or in DONE:
  - cfg_we is ignored; the table is frozen during a sweep.
  - start is ignored and is not queued.
- row_ready asserted without row_valid has no effect.
- Reset asserted mid-sweep aborts immediately. Outputs go to reset values within the same cycle and there is no done pulse. The table is cleared and must be reprogrammed.
- Total sweep latency with continuous ready: start to done = 2^N_IN + 1 + GAP*(2^N_IN-1) cycles.

Test Plan:
- N_IN=4, GAP=0. Load minterms {1,5,6,8,9,10,11,13,14}=1, rest 0. Start with row_ready tied 1 -> 16 consecutive rows, index 0..15, row_out pattern 0100011011110110. Done pulses 17 cycles after start; ones_count=9.
- Same table, row_ready toggling 1-0-0 repeatedly -> every row held stable while ready is low; no row skipped or repeated; ones_count=9.
- GAP=2, all entries 1 -> exactly 2 idle cycles between rows; ones_count=16 (5'b10000, no wrap); done at cycle 17+2*15=47 after start.
- Start and cfg_we asserted repeatedly mid-sweep -> ignored; rows match the pre-sweep table; a single done pulse.
- rst_n pulled low at row_index=7 -> outputs clear asynchronously; no done pulse; a new start after reprogramming sweeps from row 0.
- N_IN=1: table {0:1, 1:0}, start -> rows (0,1),(1,0); ones_count=1; done 3 cycles after start.

Source files
------------

// File: rtl/lut_sweep_engine.sv
// Programmable N_IN-input truth-table generator: holds a 2^N_IN-entry lookup
// table and, on start, streams every row over a valid/ready handshake.
module lut_sweep_engine #(
    parameter int N_IN = 4,
    parameter int GAP  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [N_IN-1:0] cfg_addr,
    input  logic            cfg_bit,
    input  logic            start,
    output logic            busy,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [N_IN-1:0] row_index,
    output logic            row_out,
    output logic            done,
    output logic [N_IN:0]   ones_count
);

    localparam int DEPTH = 1 << N_IN;
    localparam logic [3:0] GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_t;

    state_t          state;
    logic [DEPTH-1:0] lut;
    logic [DEPTH-1:0] lut_wr;
    logic [N_IN:0]   row_cnt;
    logic [N_IN:0]   row_nxt;
    logic [3:0]      gap_cnt;
    logic            last_row;

    assign row_index = row_cnt[N_IN-1:0];
    assign row_nxt   = row_cnt + (N_IN+1)'(1);
    assign last_row  = (row_cnt[N_IN-1:0] == {N_IN{1'b1}});

    // Table with the pending IDLE write applied, so a write to entry 0 issued
    // together with start is already visible in the first row.
    always_comb begin
        // NOTE: default assignment first so no path leaves lut_wr unassigned (no latch).
        lut_wr = lut;
        if (state == S_IDLE && cfg_we)
            lut_wr[cfg_addr] = cfg_bit;
    end

    // NOTE: the table is a small flop array, so it can be cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lut        <= '0;
            row_cnt    <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            row_valid  <= 1'b0;
            row_out    <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    lut <= lut_wr;
                    if (start) begin
                        state      <= S_SHOW;
                        row_cnt    <= '0;
                        ones_count <= '0;
                        busy       <= 1'b1;
                        row_valid  <= 1'b1;
                        row_out    <= lut_wr[0];
                    end
                end
                S_SHOW: begin
                    if (row_valid && row_ready) begin
                        ones_count <= ones_count + {{N_IN{1'b0}}, row_out};
                        if (last_row) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            row_valid <= 1'b0;
                            done      <= 1'b1;
                        end else if (GAP == 0) begin
                            row_cnt <= row_nxt;
                            row_out <= lut[row_nxt[N_IN-1:0]];
                        end else begin
                            state     <= S_GAP;
                            row_valid <= 1'b0;
                            gap_cnt   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= S_SHOW;
                        row_valid <= 1'b1;
                        row_cnt   <= row_nxt;
                        row_out   <= lut[row_nxt[N_IN-1:0]];
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Bench for lut_sweep_engine: three configurations (4/0, 4/2, 1/0) driven by
// directed sweeps and random tables, checked against an array model.
module tb_lut_sweep_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cfg_we = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       start = 1'b0;
    logic       row_ready = 1'b0;
    logic [3:0] cfg_addr = '0;
    int         sel = 0;

    logic       we_a, we_b, we_c, st_a, st_b, st_c;
    logic       busy_a, valid_a, out_a, done_a;
    logic       busy_b, valid_b, out_b, done_b;
    logic       busy_c, valid_c, out_c, done_c;
    logic [3:0] idx_a, idx_b;
    logic [0:0] idx_c;
    logic [4:0] ones_a, ones_b;
    logic [1:0] ones_c;

    assign we_a = cfg_we && sel == 0;
    assign we_b = cfg_we && sel == 1;
    assign we_c = cfg_we && sel == 2;
    assign st_a = start && sel == 0;
    assign st_b = start && sel == 1;
    assign st_c = start && sel == 2;

    lut_sweep_engine #(.N_IN(4), .GAP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .cfg_we(we_a), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit),
        .start(st_a), .busy(busy_a), .row_valid(valid_a), .row_ready(row_ready),
        .row_index(idx_a), .row_out(out_a), .done(done_a), .ones_count(ones_a));

    lut_sweep_engine #(.N_IN(4), .GAP(2)) u_b (
        .clk(clk), .rst_n(rst_n), .cfg_we(we_b), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit),
        .start(st_b), .busy(busy_b), .row_valid(valid_b), .row_ready(row_ready),
        .row_index(idx_b), .row_out(out_b), .done(done_b), .ones_count(ones_b));

    lut_sweep_engine #(.N_IN(1), .GAP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .cfg_we(we_c), .cfg_addr(cfg_addr[0:0]), .cfg_bit(cfg_bit),
        .start(st_c), .busy(busy_c), .row_valid(valid_c), .row_ready(row_ready),
        .row_index(idx_c), .row_out(out_c), .done(done_c), .ones_count(ones_c));

    logic       m_busy, m_valid, m_out, m_done;
    logic [3:0] m_index;
    logic [4:0] m_ones;

    always_comb begin
        m_busy = busy_a; m_valid = valid_a; m_out = out_a; m_done = done_a;
        m_index = idx_a; m_ones = ones_a;
        case (sel)
            1: begin
                m_busy = busy_b; m_valid = valid_b; m_out = out_b; m_done = done_b;
                m_index = idx_b; m_ones = ones_b;
            end
            2: begin
                m_busy = busy_c; m_valid = valid_c; m_out = out_c; m_done = done_c;
                m_index = {3'b000, idx_c}; m_ones = {3'b000, ones_c};
            end
            default: ;
        endcase
    end

    int tests = 0;
    int fails = 0;
    bit model [3][16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int s, input int a, input bit b);
        sel = s;
        cfg_we = 1'b1;
        cfg_addr = 4'(a);
        cfg_bit = b;
        step();
        cfg_we = 1'b0;
        model[s][a] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_index"}, m_index, 0);
        check({tag, "_out"}, m_out, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_ones"}, m_ones, 0);
    endtask

    // mode: 0 = ready always high, 1 = ready 1-0-0 pattern, 2 = random ready.
    // junk: random start/cfg_we during the sweep. wr0: write entry 0 with start.
    task automatic sweep(input int s, input int mode, input bit junk, input bit wr0, input int gap);
        int n;
        int k;
        int cyc;
        int exp_ones;
        bit fin;
        n = (s == 2) ? 2 : 16;
        k = 0;
        fin = 1'b0;
        sel = s;
        row_ready = 1'b0;
        if (wr0) begin
            model[s][0] = ~model[s][0];
            cfg_we = 1'b1;
            cfg_addr = 4'd0;
            cfg_bit = model[s][0];
        end
        exp_ones = 0;
        for (int i = 0; i < n; i++) exp_ones += int'(model[s][i]);
        start = 1'b1;
        step();
        cyc = 1;
        start = 1'b0;
        cfg_we = 1'b0;
        check("busy_after_start", m_busy, 1);
        while (!fin && cyc < 2000) begin
            if (m_done) begin
                fin = 1'b1;
                check("rows_accepted", k, n);
                check("done_ones", m_ones, exp_ones);
                check("done_busy", m_busy, 0);
                check("done_valid", m_valid, 0);
                if (mode == 0) check("done_time", cyc, n + 1 + gap * (n - 1));
            end else if (m_valid) begin
                if (k >= n) begin
                    check("extra_row", k, n - 1);
                end else begin
                    check("row_index", m_index, k);
                    check("row_out", m_out, model[s][k]);
                    check("row_busy", m_busy, 1);
                    if (mode == 0) check("row_time", cyc, 1 + k * (1 + gap));
                end
            end
            if (mode == 0) row_ready = 1'b1;
            else if (mode == 1) row_ready = (cyc % 3 == 1);
            else row_ready = 1'($urandom_range(0, 1));
            if (m_valid && row_ready) k++;
            if (junk && !m_done) begin
                start = 1'($urandom_range(0, 1));
                cfg_we = 1'($urandom_range(0, 1));
                cfg_addr = 4'($urandom);
                cfg_bit = 1'($urandom);
            end else begin
                start = 1'b0;
                cfg_we = 1'b0;
            end
            if (!fin) begin
                step();
                cyc++;
            end
        end
        row_ready = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        if (!fin) check("done_timeout", 0, 1);
        step();
        check("done_single_pulse", m_done, 0);
        check("ones_hold", m_ones, exp_ones);
        check("idle_busy", m_busy, 0);
    endtask

    initial begin
        int hit;
        foreach (model[i, j]) model[i][j] = 1'b0;

        // Reset state of every configuration.
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check_idle_outputs("reset");
        end
        @(negedge clk) rst_n = 1'b1;
        step();

        // Directed table on N_IN=4, GAP=0: minterms {1,5,6,8,9,10,11,13,14}.
        foreach (model[0][j]) prog(0, j, 1'b0);
        prog(0, 1, 1'b1);  prog(0, 5, 1'b1);  prog(0, 6, 1'b1);
        prog(0, 8, 1'b1);  prog(0, 9, 1'b1);  prog(0, 10, 1'b1);
        prog(0, 11, 1'b1); prog(0, 13, 1'b1); prog(0, 14, 1'b1);
        sweep(0, 0, 1'b0, 1'b0, 0);
        check("ones_directed", m_ones, 9);
        sweep(0, 1, 1'b0, 1'b0, 0);
        check("ones_stall", m_ones, 9);

        // GAP=2 with a full table: count must reach 16 without wrapping.
        for (int j = 0; j < 16; j++) prog(1, j, 1'b1);
        sweep(1, 0, 1'b0, 1'b0, 2);
        check("ones_full", m_ones, 16);

        // Start/cfg_we noise mid-sweep is ignored; table stays as programmed.
        sweep(0, 0, 1'b1, 1'b0, 0);
        check("ones_after_noise", m_ones, 9);

        // Write to entry 0 in the same cycle as start.
        sweep(0, 0, 1'b0, 1'b1, 0);

        // N_IN=1 table {0:1, 1:0}.
        prog(2, 0, 1'b1);
        prog(2, 1, 1'b0);
        sweep(2, 0, 1'b0, 1'b0, 0);
        check("ones_n1", m_ones, 1);
        prog(2, 1, 1'($urandom));
        sweep(2, 2, 1'b0, 1'b0, 0);

        // Reset at row 7 aborts the sweep and clears the table.
        sel = 0;
        row_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && hit == 0; c++) begin
            if (m_valid && m_index == 4'd7) hit = 1;
            else step();
        end
        check("reached_row7", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        step();
        check("no_done_in_reset", m_done, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("no_done_after_reset", m_done, 0);
        row_ready = 1'b0;
        foreach (model[i, j]) model[i][j] = 1'b0;
        sweep(0, 0, 1'b0, 1'b0, 0);
        check("ones_cleared", m_ones, 0);

        // Reprogram with random tables and sweep under random ready.
        for (int j = 0; j < 16; j++) prog(0, j, 1'($urandom));
        sweep(0, 2, 1'b1, 1'b0, 0);
        for (int j = 0; j < 16; j++) prog(1, j, 1'($urandom));
        sweep(1, 2, 1'b0, 1'b0, 2);
        sweep(1, 0, 1'b1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
